ps_to_pl_cmd_slave: RTL and testbench
=====================================

# ps_to_pl_cmd_slave

AXI4-Lite slave on the PS-to-PL control-register port that turns PS register writes into a command-word FIFO plus a control register for the PL core. It sits directly upstream of the Zynq main wrapper's control input. The PS pushes words through a memory-mapped PUSH register, and the core drains them over a valid/ready pop interface. Status, sticky overflow and FIFO head are readable back by the PS.

## Interface
- ADDR_WIDTH, 5: AXI address width; only bits [3:2] are decoded.
- DATA_WIDTH, 32: AXI data, FIFO word and ctrlOut width.
- FIFO_DEPTH, 8: power of two, 2..128. Count width is log2(FIFO_DEPTH)+1.

Ports:
- S_AXI_ACLK  in  1  single clock for the whole block.
- S_AXI_ARESETN  in  1  reset, asynchronous and active-low.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
- popData  out  DATA_WIDTH  FIFO head word.
- popValid  out  1  FIFO not empty.
- popReady  in  1  core consumes the head when popValid && popReady.
- ctrlOut  out  DATA_WIDTH  CTRL register contents.

## Operation
Register map (word offset = addr[3:2]):
- 0x00 PUSH
  - Write: push the full WDATA word into the FIFO; WSTRB is ignored.
  - If the FIFO is full, the word is dropped, BRESP = SLVERR, and the sticky overflow bit is set.
  - Read returns 0.
- 0x04 STATUS (read)
  - [7:0] count, [8] full, [9] empty, [10] overflow; other bits 0.
  - Write: WDATA[10]=1 clears overflow (write-1-to-clear); all other bits are ignored; BRESP = OKAY.
- 0x08 CTRL
  - Read/write, byte-wise per WSTRB; drives ctrlOut.
- 0x0C PEEK
  - Read returns the FIFO head without popping, or 0 if the FIFO is empty.
  - Write is ignored, BRESP = OKAY.

Write path:
- awHeld and wHeld flags latch AW and W independently. AWREADY = !awHeld && !BVALID; WREADY = !wHeld && !BVALID.
- Commit happens at the edge where (awHeld or the AW handshake completes) and (wHeld or the W handshake completes). At that edge: perform the write, clear both held flags, set BVALID and BRESP.
- BVALID clears on BREADY. No new AW/W is accepted while BVALID = 1.

Read path:
- ARREADY = !RVALID.
- On the AR handshake, register RDATA from the current state and set RVALID the next cycle.
- RVALID/RDATA hold until RREADY.

FIFO:
- Circular buffer with head/tail pointers that wrap modulo FIFO_DEPTH, plus an explicit count.
- popValid = (count != 0). popData = mem[head].
- The full test uses the pre-edge count: a PUSH while full is rejected even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full and not empty: count is unchanged, both pointers advance.
- A pop with an empty FIFO has no effect.

## Timing
- Reset (asynchronous, S_AXI_ARESETN low):
  - BVALID = 0, RVALID = 0, RDATA = 0, BRESP = 0, ctrlOut = 0.
  - count = 0, both pointers = 0, overflow = 0, popValid = 0, held flags = 0.
  - AWREADY, WREADY and ARREADY are 1 as soon as reset is released.
- Reset mid-transaction aborts everything; a pending B or R is never issued.
- A write commits at edge N: BVALID = 1 from N. Its PUSH is visible on popValid/popData from N. CTRL is visible on ctrlOut from N.
- A read accepted at edge N: RVALID = 1 from N with data sampled before edge N. A STATUS read whose AR handshake coincides with a commit edge returns the pre-commit value.
- A pop at edge N is visible in count/STATUS from N.
- Minimum write throughput: one write per 2 cycles (commit, then BREADY). Minimum read throughput: one read per 2 cycles.

## Test plan
- Reset, then AW and W presented together at 0x08 with data 0xA5A5_0001, WSTRB 4'b0011 → one cycle later BVALID = 1, BRESP = 0, ctrlOut = 0x0000_0001.
- W at 0x00 with data 0x1234_5678 given 3 cycles before AW → WREADY drops after the W handshake; commit on the AW handshake; popValid = 1, popData = 0x1234_5678; STATUS read = 0x001.
- 8 PUSHes with popReady = 0, then a 9th PUSH → STATUS = 0x108 before the 9th. The 9th gets BRESP = 2'b10, STATUS = 0x508 after it, and the head is unchanged.
- Full FIFO, 9th PUSH commit with popReady = 1 in the same cycle → push rejected with SLVERR, count = 7, pointers wrap correctly on subsequent pushes.
- STATUS write with WDATA 0x400 → overflow clears (STATUS[10] = 0). Empty FIFO PEEK → 0. After PUSH 0xDEAD_BEEF, PEEK → 0xDEAD_BEEF with count unchanged.
- Deassert S_AXI_ARESETN with BVALID = 1 and 3 words queued → BVALID, popValid, count and ctrlOut go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ps_to_pl_cmd_slave_if.sv
// Bus bundle for the PS-to-PL command slave: the AXI4-Lite control port,
// the command-word pop port and the CTRL register output.
//
// Handshake rule for every channel (AW, W, B, AR, R, pop): a transfer
// happens on the rising clock edge where VALID and READY are both high.
// The source holds VALID and its payload steady until that edge. READY
// may be high before VALID arrives.
interface ps_to_pl_cmd_slave_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;
    logic [DATA_WIDTH-1:0]   popData;
    logic                    popValid;
    logic                    popReady;
    logic [DATA_WIDTH-1:0]   ctrlOut;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY,
        output popData, popValid,
        input  popReady,
        output ctrlOut
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY,
        input  popData, popValid,
        output popReady,
        input  ctrlOut
    );
endinterface

// File: rtl/ps_to_pl_cmd_slave.sv
// AXI4-Lite slave that turns PS writes to the PUSH register into a
// command-word FIFO drained by the PL core, plus a byte-writable CTRL
// register. STATUS exposes count/full/empty and a sticky overflow flag;
// PEEK returns the FIFO head without consuming it.
module ps_to_pl_cmd_slave #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input logic S_AXI_ACLK,
    input logic S_AXI_ARESETN,
    ps_to_pl_cmd_slave_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_PUSH   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_PEEK   = 2'd3
    } reg_sel_e;

    // Write channel state
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  bvalid;
    logic [1:0]            bresp;

    // Read channel state
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    // Registers and FIFO
    logic [DATA_WIDTH-1:0] ctrl;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic                  aw_ready;
    logic                  w_ready;
    logic                  ar_ready;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    reg_sel_e              wr_sel;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop_ok;
    logic [DATA_WIDTH-1:0] status_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_bits;

    // No new address or data is taken while a write response is pending.
    assign aw_ready = !aw_held && !bvalid;
    assign w_ready  = !w_held && !bvalid;
    assign ar_ready = !rvalid;

    assign aw_fire = bus.S_AXI_AWVALID && aw_ready;
    assign w_fire  = bus.S_AXI_WVALID && w_ready;
    assign ar_fire = bus.S_AXI_ARVALID && ar_ready;

    // A write commits on the first edge where both halves are available,
    // either already latched or handshaking right now.
    assign commit  = (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_addr = aw_held ? aw_addr_q : bus.S_AXI_AWADDR;
    assign wr_data = w_held ? w_data_q : bus.S_AXI_WDATA;
    assign wr_strb = w_held ? w_strb_q : bus.S_AXI_WSTRB;
    assign wr_sel  = reg_sel_e'(wr_addr[3:2]);

    // Full is judged on the pre-edge count, so a same-cycle pop never
    // makes room for a push.
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_req   = commit && (wr_sel == REG_PUSH);
    assign push_ok    = push_req && !fifo_full;
    assign pop_ok     = !fifo_empty && bus.popReady;

    // STATUS layout: count, full, empty, sticky overflow.
    always_comb begin
        status_word       = '0;
        status_word[7:0]  = 8'(count);
        status_word[8]    = fifo_full;
        status_word[9]    = fifo_empty;
        status_word[10]   = overflow;
    end

    // Read data mux on the current (pre-edge) register state.
    always_comb begin
        rd_word = '0;
        case (reg_sel_e'(bus.S_AXI_ARADDR[3:2]))
            REG_STATUS: rd_word = status_word;
            REG_CTRL:   rd_word = ctrl;
            REG_PEEK:   if (!fifo_empty) rd_word = mem[head];
            default:    rd_word = '0;
        endcase
    end

    // Write channel: hold AW/W independently, commit, then issue B.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= (push_req && fifo_full) ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= bus.S_AXI_AWADDR;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= bus.S_AXI_WDATA;
                w_strb_q <= bus.S_AXI_WSTRB;
            end
            if (bvalid && bus.S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // CTRL byte writes and the sticky overflow flag.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl     <= '0;
            overflow <= 1'b0;
        end else begin
            if (commit && (wr_sel == REG_CTRL)) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (wr_strb[i]) ctrl[8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (commit && (wr_sel == REG_STATUS) && wr_data[10]) begin
                overflow <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + PTR_W'(1);
            if (pop_ok)  head <= head + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents beyond the occupied range are don't-care.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok) mem[tail] <= wr_data;
    end

    // Read channel: capture data on the AR handshake, hold until RREADY.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_fire) begin
            rvalid <= 1'b1;
            rdata  <= rd_word;
        end else if (rvalid && bus.S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    assign bus.S_AXI_AWREADY = aw_ready;
    assign bus.S_AXI_WREADY  = w_ready;
    assign bus.S_AXI_BVALID  = bvalid;
    assign bus.S_AXI_BRESP   = bresp;
    assign bus.S_AXI_ARREADY = ar_ready;
    assign bus.S_AXI_RVALID  = rvalid;
    assign bus.S_AXI_RDATA   = rdata;
    assign bus.S_AXI_RRESP   = RESP_OKAY;
    assign bus.popValid      = !fifo_empty;
    assign bus.popData       = mem[head];
    assign bus.ctrlOut       = ctrl;

    // Protection bits and undecoded address bits carry no meaning here.
    assign unused_bits = ^{bus.S_AXI_AWPROT, bus.S_AXI_ARPROT, wr_addr, bus.S_AXI_ARADDR};
endmodule

// File: tb/tb_ps_to_pl_cmd_slave.sv
// Bench for ps_to_pl_cmd_slave: directed scenarios with literal
// expectations, a randomized mixed phase, and a queue-based model that is
// compared against the DUT outputs on every falling edge.
module tb_ps_to_pl_cmd_slave;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps_to_pl_cmd_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ps_to_pl_cmd_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .bus          (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_ctrl     = '0;
    bit            m_ovf      = 1'b0;
    bit            m_aw_held  = 1'b0;
    bit            m_w_held   = 1'b0;
    bit            m_bvalid   = 1'b0;
    bit            m_rvalid   = 1'b0;
    logic [1:0]    m_bresp    = 2'b00;
    logic [DW-1:0] m_rdata    = '0;
    logic [AW-1:0] m_aw_addr  = '0;
    logic [DW-1:0] m_w_data   = '0;
    logic [3:0]    m_w_strb   = '0;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = '0;
        case (a[3:2])
            2'd1: begin
                v[7:0] = 8'(m_q.size());
                v[8]   = (m_q.size() == DEPTH);
                v[9]   = (m_q.size() == 0);
                v[10]  = m_ovf;
            end
            2'd2: v = m_ctrl;
            2'd3: if (m_q.size() != 0) v = m_q[0];
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ctrl = '0; m_ovf = 0; m_aw_held = 0; m_w_held = 0;
            m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rdata = '0;
        end else begin
            bit aw_f, w_f, ar_f, full_pre, commit;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [3:0]    s;
            aw_f     = bus.S_AXI_AWVALID && !m_aw_held && !m_bvalid;
            w_f      = bus.S_AXI_WVALID && !m_w_held && !m_bvalid;
            ar_f     = bus.S_AXI_ARVALID && !m_rvalid;
            full_pre = (m_q.size() == DEPTH);
            // reads see the state before this edge
            if (ar_f) begin
                m_rdata  = model_read(bus.S_AXI_ARADDR);
                m_rvalid = 1;
            end else if (m_rvalid && bus.S_AXI_RREADY) begin
                m_rvalid = 0;
            end
            if (m_q.size() != 0 && bus.popReady) void'(m_q.pop_front());
            commit = (m_aw_held || aw_f) && (m_w_held || w_f);
            a = m_aw_held ? m_aw_addr : bus.S_AXI_AWADDR;
            d = m_w_held ? m_w_data : bus.S_AXI_WDATA;
            s = m_w_held ? m_w_strb : bus.S_AXI_WSTRB;
            if (commit) begin
                m_bresp = 2'b00;
                case (a[3:2])
                    2'd0: if (full_pre) begin m_bresp = 2'b10; m_ovf = 1; end
                          else m_q.push_back(d);
                    2'd1: if (d[10]) m_ovf = 0;
                    2'd2: for (int i = 0; i < 4; i++) if (s[i]) m_ctrl[8*i +: 8] = d[8*i +: 8];
                    default: ;
                endcase
                m_aw_held = 0; m_w_held = 0; m_bvalid = 1;
            end else begin
                if (aw_f) begin m_aw_held = 1; m_aw_addr = bus.S_AXI_AWADDR; end
                if (w_f)  begin m_w_held = 1; m_w_data = bus.S_AXI_WDATA; m_w_strb = bus.S_AXI_WSTRB; end
                if (m_bvalid && bus.S_AXI_BREADY) m_bvalid = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("awready", bus.S_AXI_AWREADY, !m_aw_held && !m_bvalid);
            check("wready", bus.S_AXI_WREADY, !m_w_held && !m_bvalid);
            check("arready", bus.S_AXI_ARREADY, !m_rvalid);
            check("bvalid", bus.S_AXI_BVALID, m_bvalid);
            if (m_bvalid) check("bresp", bus.S_AXI_BRESP, m_bresp);
            check("rvalid", bus.S_AXI_RVALID, m_rvalid);
            if (m_rvalid) begin
                check("rdata", bus.S_AXI_RDATA, m_rdata);
                check("rresp", bus.S_AXI_RRESP, 2'b00);
            end
            check("popValid", bus.popValid, m_q.size() != 0);
            if (m_q.size() != 0) check("popData", bus.popData, m_q[0]);
            check("ctrlOut", bus.ctrlOut, m_ctrl);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input bit pop_with, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int t = 0;
        resp = 2'b11;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            bus.S_AXI_AWADDR  = addr;
            bus.S_AXI_WDATA   = data;
            bus.S_AXI_WSTRB   = strb;
            bus.S_AXI_AWVALID = !aw_done && (t >= aw_dly);
            bus.S_AXI_WVALID  = !w_done && (t >= w_dly);
            if (pop_with) bus.popReady = (t == 0);
            aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            t++;
            if (t > 200) begin timeout_fail("write handshake"); break; end
        end
        @(negedge clk);
        bus.S_AXI_AWVALID = 0;
        bus.S_AXI_WVALID  = 0;
        if (pop_with) bus.popReady = 0;
        t = 0;
        while (!bus.S_AXI_BVALID && t < 50) begin @(negedge clk); t++; end
        if (!bus.S_AXI_BVALID) begin
            timeout_fail("write response");
        end else begin
            resp = bus.S_AXI_BRESP;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.S_AXI_BREADY = 1;
            @(negedge clk);
            bus.S_AXI_BREADY = 0;
        end
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
        bit hs = 0;
        int t = 0;
        data = 'x;
        while (!hs) begin
            @(negedge clk);
            bus.S_AXI_ARVALID = 1;
            bus.S_AXI_ARADDR  = addr;
            hs = bus.S_AXI_ARREADY;
            @(posedge clk);
            t++;
            if (t > 200) begin timeout_fail("read handshake"); break; end
        end
        @(negedge clk);
        bus.S_AXI_ARVALID = 0;
        t = 0;
        while (!bus.S_AXI_RVALID && t < 50) begin @(negedge clk); t++; end
        if (!bus.S_AXI_RVALID) begin
            timeout_fail("read data");
        end else begin
            data = bus.S_AXI_RDATA;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.S_AXI_RREADY = 1;
            @(negedge clk);
            bus.S_AXI_RREADY = 0;
        end
    endtask

    task automatic drain();
        int t = 0;
        bus.popReady = 1;
        while (bus.popValid && t < 40) begin @(negedge clk); t++; end
        bus.popReady = 0;
        check("drain empty", bus.popValid, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    logic [1:0]    resp;
    logic [DW-1:0] rd;
    bit            wr_done = 0, rd_done = 0;

    initial begin
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 0;
        bus.S_AXI_BREADY = 0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 0;
        bus.S_AXI_RREADY = 0;  bus.popReady = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("reset popValid", bus.popValid, 1'b0);
        check("reset ctrlOut", bus.ctrlOut, 32'h0);
        check("reset bvalid", bus.S_AXI_BVALID, 1'b0);
        check("reset awready", bus.S_AXI_AWREADY, 1'b1);
        check("reset arready", bus.S_AXI_ARREADY, 1'b1);

        // CTRL byte write, AW and W together
        axi_write(5'h08, 32'hA5A5_0001, 4'b0011, 0, 0, 0, resp);
        check("ctrl bresp", resp, 2'b00);
        check("ctrl value", bus.ctrlOut, 32'h0000_0001);

        // W leads AW by 3 cycles
        axi_write(5'h00, 32'h1234_5678, 4'hF, 3, 0, 0, resp);
        check("push1 popValid", bus.popValid, 1'b1);
        check("push1 popData", bus.popData, 32'h1234_5678);
        axi_read(5'h04, rd);
        check("status one", rd, 32'h001);

        // fill to 8, then overflow
        for (int i = 1; i < 8; i++) axi_write(5'h00, 32'h100 + i, 4'hF, 0, 0, 0, resp);
        axi_read(5'h04, rd);
        check("status full", rd, 32'h108);
        axi_write(5'h00, 32'hBAD0_0009, 4'hF, 0, 0, 0, resp);
        check("overflow bresp", resp, 2'b10);
        axi_read(5'h04, rd);
        check("status overflow", rd, 32'h508);
        axi_read(5'h0C, rd);
        check("head unchanged", rd, 32'h1234_5678);

        // clear overflow
        axi_write(5'h04, 32'h400, 4'hF, 0, 0, 0, resp);
        axi_read(5'h04, rd);
        check("ovf cleared", rd, 32'h108);

        // push while full with a same-cycle pop: still rejected
        axi_write(5'h00, 32'hBAD0_000A, 4'hF, 0, 0, 1, resp);
        check("full+pop bresp", resp, 2'b10);
        axi_read(5'h04, rd);
        check("full+pop status", rd, 32'h407);
        axi_read(5'h0C, rd);
        check("full+pop head", rd, 32'h101);
        axi_write(5'h00, 32'hC0DE_0001, 4'hF, 1, 2, 0, resp);
        check("wrap push bresp", resp, 2'b00);
        axi_read(5'h04, rd);
        check("wrap status", rd, 32'h508);
        axi_write(5'h04, 32'h400, 4'hF, 0, 0, 0, resp);
        drain();

        // PEEK empty and non-empty
        axi_read(5'h0C, rd);
        check("peek empty", rd, 32'h0);
        axi_write(5'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp);
        axi_read(5'h0C, rd);
        check("peek value", rd, 32'hDEAD_BEEF);
        axi_read(5'h04, rd);
        check("peek keeps count", rd, 32'h001);

        // randomized mixed traffic
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    int sel;
                    logic [AW-1:0] a;
                    logic [DW-1:0] d;
                    logic [1:0]    r;
                    sel = $urandom_range(0, 99);
                    a = (sel < 70) ? 5'h00 : (sel < 80) ? 5'h04 : (sel < 95) ? 5'h08 : 5'h0C;
                    a = a | 5'($urandom_range(0, 1) << 4);
                    d = $urandom;
                    axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                              $urandom_range(0, 3), 0, r);
                end
                wr_done = 1;
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [DW-1:0] v;
                    axi_read(5'($urandom_range(0, 31)), v);
                end
                rd_done = 1;
            end
            begin
                while (!(wr_done && rd_done)) begin
                    @(negedge clk);
                    bus.popReady = ($urandom_range(0, 2) == 0);
                end
                bus.popReady = 0;
            end
        join

        // asynchronous reset with a pending B and 3 words queued
        @(negedge clk);
        drain();
        for (int i = 0; i < 3; i++) axi_write(5'h00, $urandom, 4'hF, 0, 0, 0, resp);
        @(negedge clk);
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_WDATA = 32'hFFFF_FFFF; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
        check("pre-reset bvalid", bus.S_AXI_BVALID, 1'b1);
        check("pre-reset ctrlOut", bus.ctrlOut, 32'hFFFF_FFFF);
        #2 rst_n = 0;
        #1;
        check("async bvalid", bus.S_AXI_BVALID, 1'b0);
        check("async popValid", bus.popValid, 1'b0);
        check("async ctrlOut", bus.ctrlOut, 32'h0);
        @(negedge clk);
        rst_n = 1;
        axi_read(5'h04, rd);
        check("post-reset status", rd, 32'h200);
        axi_read(5'h08, rd);
        check("post-reset ctrl", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
